// File: rtl/btn_counter_pkg.sv
// Shared types and defaults for the button-driven counter stage.
package btn_counter_pkg;

    localparam int DEFAULT_WIDTH           = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Bit positions of each button inside the packed button vectors
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_LOAD = 2;
    localparam int NUM_BTNS = 3;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        WAIT_REL
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_UP,
        CMD_DOWN
    } cmd_t;

    // Load wins over everything; up and down together cancel each other out
    function automatic cmd_t select_cmd(input logic load, input logic up, input logic down);
        cmd_t cmd;
        cmd = CMD_NONE;
        if (load) begin
            cmd = CMD_LOAD;
        end else if (up && !down) begin
            cmd = CMD_UP;
        end else if (down && !up) begin
            cmd = CMD_DOWN;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/btn_counter_stage_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
// stb follows the synchronised level only after it has differed for
// DEBOUNCE_CYCLES consecutive cycles; rise pulses on the edge stb goes high.
module btn_debounce
    import btn_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic stb,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] cnt_reg;
    logic          stb_reg;
    logic          rise_reg;

    // Synchronise, count consecutive differing cycles, accept on the last one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= '0;
            stb_reg   <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg != stb_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    stb_reg  <= sync2_reg;
                    cnt_reg  <= '0;
                    rise_reg <= sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign stb  = stb_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/btn_counter_stage.sv
// Debounces up/down/load buttons and drives a WIDTH-bit counter. Each
// accepted command produces a one-cycle en_out strobe with the new word on
// d_out for a downstream enable-gated register. Further presses are ignored
// until every button has been released.
module btn_counter_stage
    import btn_counter_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             en_out,
    output logic [WIDTH-1:0] d_out,
    output logic             overflow,
    output logic             underflow
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] stb_vec;
    logic [NUM_BTNS-1:0] rise_vec;

    assign btn_raw[BTN_UP]   = btn_up;
    assign btn_raw[BTN_DOWN] = btn_down;
    assign btn_raw[BTN_LOAD] = btn_load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_db
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk  (clk),
                .reset(reset),
                .btn  (btn_raw[gi]),
                .stb  (stb_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    state_t           state_reg;
    state_t           state_next;
    cmd_t             cmd_sel;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             en_reg;
    logic             en_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             udf_reg;
    logic             udf_next;

    // Rise pulses are already registered, so the command decode has no input path
    assign cmd_sel = select_cmd(rise_vec[BTN_LOAD], rise_vec[BTN_UP], rise_vec[BTN_DOWN]);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one APPLY cycle per command, then lock out until release
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (cmd_sel != CMD_NONE) state_next = APPLY;
            APPLY:    state_next = WAIT_REL;
            WAIT_REL: if (stb_vec == '0) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output logic: compute the word and flags that become visible in APPLY
    always_comb begin
        q_next   = q_reg;
        en_next  = 1'b0;
        ovf_next = 1'b0;
        udf_next = 1'b0;
        if (state_reg == IDLE) begin
            case (cmd_sel)
                CMD_LOAD: begin
                    q_next  = load_val;
                    en_next = 1'b1;
                end
                CMD_UP: begin
                    q_next   = q_reg + 1'b1;
                    ovf_next = &q_reg;
                    en_next  = 1'b1;
                end
                CMD_DOWN: begin
                    q_next   = q_reg - 1'b1;
                    udf_next = ~|q_reg;
                    en_next  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output registers so every port is driven straight from a flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg   <= '0;
            en_reg  <= 1'b0;
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            en_reg  <= en_next;
            ovf_reg <= ovf_next;
            udf_reg <= udf_next;
        end
    end

    assign q         = q_reg;
    assign d_out     = q_reg;
    assign en_out    = en_reg;
    assign overflow  = ovf_reg;
    assign underflow = udf_reg;

endmodule

// File: tb/tb_btn_counter_stage.sv
// Randomised self-checking bench for btn_counter_stage with a short debounce.
module tb_btn_counter_stage;

    localparam int W    = 4;
    localparam int N    = 4;
    localparam int MAXV = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         btn_up = 1'b0;
    logic         btn_down = 1'b0;
    logic         btn_load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         en_out;
    logic [W-1:0] d_out;
    logic         overflow;
    logic         underflow;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] q_model = '0;

    btn_counter_stage #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_load (btn_load),
        .load_val (load_val),
        .q        (q),
        .en_out   (en_out),
        .d_out    (d_out),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mask bits: [0]=up [1]=down [2]=load; all pressed together for len cycles
    task automatic run_txn(input logic [2:0] mask, input int len, input logic [W-1:0] lv,
                           input string tag);
        logic [W-1:0] exp_q;
        bit           exp_en;
        bit           exp_ovf;
        bit           exp_udf;
        int           en_cnt;
        int           en_at;
        bit           ovf_at;
        bit           udf_at;
        int           spurious;
        exp_q   = q_model;
        exp_en  = 0;
        exp_ovf = 0;
        exp_udf = 0;
        if (len >= N) begin
            if (mask[2]) begin
                exp_q  = lv;
                exp_en = 1;
            end else if (mask[0] && !mask[1]) begin
                exp_q   = W'((int'(q_model) + 1) % MAXV);
                exp_ovf = (int'(q_model) == MAXV - 1);
                exp_en  = 1;
            end else if (mask[1] && !mask[0]) begin
                exp_q   = W'((int'(q_model) + MAXV - 1) % MAXV);
                exp_udf = (q_model == 0);
                exp_en  = 1;
            end
        end
        en_cnt = 0; en_at = -1; ovf_at = 0; udf_at = 0; spurious = 0;
        load_val = lv;
        {btn_load, btn_down, btn_up} = mask;
        for (int c = 1; c <= len + N + 10; c++) begin
            step();
            if (en_out) begin
                en_cnt++;
                en_at  = c;
                ovf_at = overflow;
                udf_at = underflow;
            end else if (overflow || underflow) begin
                spurious++;
            end
            if (d_out !== q) spurious++;
            if (c == len) {btn_load, btn_down, btn_up} = 3'b000;
        end
        vectors++;
        if (en_cnt !== int'(exp_en)) begin
            miscompares++;
            $display("FAIL %s en_count got=%0d exp=%0d", tag, en_cnt, exp_en);
        end
        if (exp_en) begin
            vectors++;
            if (en_at !== N + 3) begin
                miscompares++;
                $display("FAIL %s en_edge got=%0d exp=%0d", tag, en_at, N + 3);
            end
            vectors++;
            if (ovf_at !== exp_ovf || udf_at !== exp_udf) begin
                miscompares++;
                $display("FAIL %s flags got=ovf%0d/udf%0d exp=ovf%0d/udf%0d", tag, ovf_at,
                         udf_at, exp_ovf, exp_udf);
            end
        end
        vectors++;
        if (q !== exp_q || d_out !== exp_q) begin
            miscompares++;
            $display("FAIL %s q got=%0d d_out=%0d exp=%0d", tag, q, d_out, exp_q);
        end
        vectors++;
        if (spurious != 0) begin
            miscompares++;
            $display("FAIL %s stray_flags_or_dout got=%0d exp=0", tag, spurious);
        end
        q_model = exp_q;
        $display("txn %s mask=%b len=%0d lv=%0d en=%0d q=%0d exp_q=%0d", tag, mask, len, lv,
                 en_cnt, q, exp_q);
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (q !== 0 || en_out !== 0 || d_out !== 0 || overflow !== 0 || underflow !== 0)
                bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset_idle bad_cycles got=%0d exp=0", bad);
        end
        q_model = '0;
        $display("txn reset_idle q=%0d en=%0d", q, en_out);
    endtask

    task automatic test_up_hold();
        run_txn(3'b001, 12, '0, "up_hold");
        run_txn(3'b001, 12, '0, "up_again");
    endtask

    task automatic test_glitch();
        run_txn(3'b010, 2, '0, "down_glitch2");
        run_txn(3'b010, 3, '0, "down_glitch3");
        run_txn(3'b010, 4, '0, "down_pulse4");
    endtask

    task automatic test_wrap();
        run_txn(3'b100, 8, W'(MAXV - 1), "load_max");
        run_txn(3'b001, 8, '0, "up_wrap");
        run_txn(3'b010, 8, '0, "down_wrap");
    endtask

    task automatic test_priority();
        int en_cnt;
        run_txn(3'b101, 8, W'(9), "up_and_load");
        run_txn(3'b011, 8, '0, "up_and_down");
        // Down pressed while up is still held must be discarded
        en_cnt = 0;
        btn_up = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (en_out) en_cnt++;
            if (c == 10) btn_down = 1'b1;
            if (c == 22) btn_up = 1'b0;
            if (c == 25) btn_down = 1'b0;
        end
        q_model = W'((int'(q_model) + 1) % MAXV);
        vectors++;
        if (en_cnt != 1 || q !== q_model) begin
            miscompares++;
            $display("FAIL lockout en_count got=%0d exp=1 q got=%0d exp=%0d", en_cnt, q,
                     q_model);
        end
        $display("txn lockout en=%0d q=%0d exp_q=%0d", en_cnt, q, q_model);
        run_txn(3'b010, 6, '0, "down_after_lockout");
    endtask

    task automatic test_async_reset();
        logic [W-1:0] q_before;
        run_txn(3'b100, 6, W'(5), "load5");
        q_before = q;
        reset = 1'b1;
        #2;
        vectors++;
        if (q !== 0 || d_out !== 0) begin
            miscompares++;
            $display("FAIL async_reset q got=%0d exp=0", q);
        end
        $display("txn async_reset q_before=%0d q_now=%0d", q_before, q);
        step();
        step();
        reset = 1'b0;
        q_model = '0;
    endtask

    task automatic test_reset_held();
        int bad;
        btn_up = 1'b1;
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        bad = 0;
        for (int k = 1; k <= N + 3; k++) begin
            step();
            if (q !== ((k >= N + 3) ? W'(1) : W'(0))) bad++;
            if (en_out !== (k == N + 3)) bad++;
        end
        btn_up = 1'b0;
        for (int k = 0; k < N + 8; k++) begin
            step();
            if (en_out !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0 || q !== W'(1)) begin
            miscompares++;
            $display("FAIL reset_held bad_cycles got=%0d q got=%0d exp=1", bad, q);
        end
        q_model = W'(1);
        $display("txn reset_held q=%0d", q);
    endtask

    task automatic test_random();
        logic [2:0]   mask;
        int           len;
        logic [W-1:0] lv;
        for (int i = 0; i < 30; i++) begin
            mask = 3'($urandom_range(1, 7));
            len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1))
                                               : int'($urandom_range(N, 16));
            lv   = W'($urandom);
            run_txn(mask, len, lv, "random");
        end
    endtask

    initial begin
        test_reset();
        test_up_hold();
        test_glitch();
        test_wrap();
        test_priority();
        test_async_reset();
        test_reset_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_counter_stage.md
Name: btn_counter_stage

Overview:
- Upstream stage for the team's enable-gated D-register banks.
- Synchronises and debounces three push-buttons (up, down, load) and keeps a WIDTH-bit count.
- On every accepted command, issues a one-cycle enable strobe plus the new data word, which the downstream register captures.
- Also exposes its internal count and wrap flags directly.

Parameters:
- WIDTH, 4: counter/data width in bits.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required to accept a level change. Must be 2 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_up  in  1  raw asynchronous button, increment.
- btn_down  in  1  raw asynchronous button, decrement.
- btn_load  in  1  raw asynchronous button, load load_val.
- load_val  in  WIDTH  value loaded on a load command; sampled in the apply cycle.
- q  out  WIDTH  current count.
- en_out  out  1  one-cycle strobe to the downstream register enable.
- d_out  out  WIDTH  data to the downstream register; equals q.
- overflow  out  1  one-cycle pulse when up wraps max to 0.
- underflow  out  1  one-cycle pulse when down wraps 0 to max.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. Reset drives q=0, d_out=0, en_out=0, overflow=0, underflow=0, all synchronisers and debounce state to 0, FSM to IDLE.
- Per-button debounce:
  - 2-flop synchroniser produces s.
  - A counter increments while s differs from the debounced level stb; it clears when they are equal.
  - When the counter is at DEBOUNCE_CYCLES-1 and s still differs, stb takes s and the counter clears.
  - The rise pulse is registered and asserted for exactly one cycle, on the same edge that stb rises.
- Latency: raw button high before edge 1 gives rise pulse high after edge 2+N, where N = DEBOUNCE_CYCLES. q, d_out, en_out and the flags update at edge 3+N.
- Glitches: a glitch shorter than N synchronised cycles produces no pulse.
- FSM states: IDLE, APPLY, WAIT_REL.
  - IDLE: any rise pulse latches a command and moves to APPLY next cycle.
  - Command priority: load > up > down.
  - Simultaneous up and down pulses with no load: no command, stay IDLE.
  - APPLY (1 cycle): registered update of q and d_out; en_out=1 for this one cycle. Then go to WAIT_REL.
  - WAIT_REL: stay until all three stb are 0, then return to IDLE. Rise pulses arriving here are discarded.
- Arithmetic: modulo 2^WIDTH.
  - Up at 2^WIDTH-1 gives 0, overflow=1 in the same cycle as en_out.
  - Down at 0 gives 2^WIDTH-1, underflow=1.
  - Load never sets a flag.
- Outputs outside APPLY: en_out, overflow and underflow are 0. q and d_out hold their value.
- Reset mid-operation: any partial debounce or pending APPLY is dropped.
  - A button held through reset deassertion counts as a fresh press, producing its pulse N+3 edges after reset release.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Package btn_counter_pkg:
  - state enumeration (IDLE, APPLY, WAIT_REL);
  - command encoding (CMD_NONE, CMD_LOAD, CMD_UP, CMD_DOWN);
  - default WIDTH and DEBOUNCE_CYCLES constants.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk, reset, btn, stb, rise), instantiated three times.
- The top level holds the FSM, counter and flags.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset then idle: q=0, en_out=0 for 20 cycles. Assert reset mid-run with q=5: q=0 immediately, asynchronously, before the next edge.
2. btn_up held 12 cycles from q=0: en_out high exactly one cycle, 7 edges after press. q=1, d_out=1. No second increment while held. Release then press again gives q=2.
3. 2-cycle glitch on btn_down: no en_out, q unchanged. A 3-cycle glitch is also rejected. A 4-cycle-stable synchronised pulse is accepted.
4. Wrap: load_val=15, press load, then press up: q=15, then q=0 with overflow=1 in the en_out cycle. Press down: q=15, underflow=1.
5. Priority and lockout:
   - up and load rising on the same cycle with load_val=9: q=9.
   - up and down on the same cycle: no en_out.
   - press down while up still held: ignored until both are released.
6. Reset released with btn_up held: q stays 0 until edge 7 after release, then q=1.
